// File: rtl/tdc_spi_arbiter_if.sv
// Bundle between the two requesters, the arbiter and the byte interface of the TDC SPI master.
// Handshake: reqN is a level held until doneN; tx_ackN, rx_validN, doneN, errN and m_start are one-cycle pulses, with no back-pressure.
interface tdc_spi_arbiter_if;
   logic       req0;
   logic       req1;
   logic [3:0] len0;
   logic [3:0] len1;
   logic [7:0] tx0;
   logic [7:0] tx1;
   logic       grant0;
   logic       grant1;
   logic       tx_ack0;
   logic       tx_ack1;
   logic       rx_valid0;
   logic       rx_valid1;
   logic [7:0] rx_data;
   logic       done0;
   logic       done1;
   logic       err0;
   logic       err1;
   logic       m_start;
   logic [7:0] m_data_in;
   logic [7:0] m_data_out;
   logic       m_busy;
   logic       m_new_data;
   logic       m_cs_end;

   modport slave (
      input  req0, req1, len0, len1, tx0, tx1,
      output grant0, grant1, tx_ack0, tx_ack1, rx_valid0, rx_valid1, rx_data,
      output done0, done1, err0, err1, m_start, m_data_in,
      input  m_data_out, m_busy, m_new_data, m_cs_end
   );

   modport master (
      output req0, req1, len0, len1, tx0, tx1,
      input  grant0, grant1, tx_ack0, tx_ack1, rx_valid0, rx_valid1, rx_data,
      input  done0, done1, err0, err1, m_start, m_data_in,
      output m_data_out, m_busy, m_new_data, m_cs_end
   );
endinterface

// File: rtl/tdc_spi_arbiter.sv
// Shares one TDC SPI master between the measurement controller (port 0) and the host path (port 1),
// running one fixed-length multi-byte transaction per grant and releasing only after chip-select ends.
module tdc_spi_arbiter #(
   parameter int MAX_CONSEC = 4,
   parameter int TIMEOUT    = 1000
) (
   input  logic                    clk,
   input  logic                    rst,
   tdc_spi_arbiter_if.slave        bus,
   output logic [2:0]              state_o
);
   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_WAIT_BYTE = 3'd2,
      S_WAIT_CS   = 3'd3,
      S_DONE      = 3'd4
   } state_t;

   localparam logic [2:0]  STREAK_CAP = 3'(MAX_CONSEC);
   localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT - 1);

   state_t      state_q;
   logic        owner_q;
   logic [3:0]  remaining_q;
   logic [2:0]  streak_q;
   logic [15:0] tmo_q;
   logic [1:0]  grant_q;
   logic [1:0]  tx_ack_q;
   logic [1:0]  rx_valid_q;
   logic [1:0]  done_q;
   logic [1:0]  err_q;
   logic [7:0]  rx_data_q;
   logic        m_start_q;
   logic [7:0]  m_data_in_q;

   logic        pick1;
   logic [3:0]  len_pick;
   logic [7:0]  tx_owner;
   logic [1:0]  owner_mask;

   // Port 1 wins a tie only once port 0 has used up its streak of back-to-back grants.
   assign pick1      = bus.req1 & (~bus.req0 | (streak_q >= STREAK_CAP));
   assign len_pick   = pick1 ? bus.len1 : bus.len0;
   assign tx_owner   = owner_q ? bus.tx1 : bus.tx0;
   assign owner_mask = owner_q ? 2'b10 : 2'b01;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         owner_q     <= 1'b0;
         remaining_q <= '0;
         streak_q    <= '0;
         tmo_q       <= '0;
         grant_q     <= '0;
         tx_ack_q    <= '0;
         rx_valid_q  <= '0;
         done_q      <= '0;
         err_q       <= '0;
         rx_data_q   <= '0;
         m_start_q   <= 1'b0;
         m_data_in_q <= '0;
      end else begin
         tx_ack_q   <= '0;
         rx_valid_q <= '0;
         done_q     <= '0;
         err_q      <= '0;
         m_start_q  <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (bus.req0 | bus.req1) begin
                  owner_q     <= pick1;
                  grant_q     <= pick1 ? 2'b10 : 2'b01;
                  remaining_q <= len_pick;
                  m_data_in_q <= pick1 ? bus.tx1 : bus.tx0;
                  tmo_q       <= '0;
                  if (pick1) begin
                     streak_q <= '0;
                  end else if (bus.req1 && streak_q != 3'd7) begin
                     streak_q <= streak_q + 3'd1;
                  end
                  if (len_pick == 4'd0) begin
                     done_q  <= pick1 ? 2'b10 : 2'b01;
                     state_q <= S_DONE;
                  end else begin
                     state_q <= S_START;
                  end
               end
            end
            S_START: begin
               if (!bus.m_busy) begin
                  m_start_q   <= 1'b1;
                  m_data_in_q <= tx_owner;
                  tmo_q       <= '0;
                  state_q     <= S_WAIT_BYTE;
               end
            end
            S_WAIT_BYTE: begin
               if (bus.m_new_data) begin
                  rx_data_q   <= bus.m_data_out;
                  rx_valid_q  <= owner_mask;
                  tx_ack_q    <= owner_mask;
                  remaining_q <= remaining_q - 4'd1;
                  tmo_q       <= '0;
                  state_q     <= (remaining_q == 4'd1) ? S_WAIT_CS : S_START;
               end else if (tmo_q == TMO_LAST) begin
                  done_q  <= owner_mask;
                  err_q   <= owner_mask;
                  state_q <= S_DONE;
               end else begin
                  tmo_q <= tmo_q + 16'd1;
               end
            end
            S_WAIT_CS: begin
               if (bus.m_cs_end) begin
                  done_q  <= owner_mask;
                  state_q <= S_DONE;
               end else if (tmo_q == TMO_LAST) begin
                  done_q  <= owner_mask;
                  err_q   <= owner_mask;
                  state_q <= S_DONE;
               end else begin
                  tmo_q <= tmo_q + 16'd1;
               end
            end
            S_DONE: begin
               grant_q <= '0;
               tmo_q   <= '0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign state_o       = state_q;
   assign bus.grant0    = grant_q[0];
   assign bus.grant1    = grant_q[1];
   assign bus.tx_ack0   = tx_ack_q[0];
   assign bus.tx_ack1   = tx_ack_q[1];
   assign bus.rx_valid0 = rx_valid_q[0];
   assign bus.rx_valid1 = rx_valid_q[1];
   assign bus.rx_data   = rx_data_q;
   assign bus.done0     = done_q[0];
   assign bus.done1     = done_q[1];
   assign bus.err0      = err_q[0];
   assign bus.err1      = err_q[1];
   assign bus.m_start   = m_start_q;
   assign bus.m_data_in = m_data_in_q;
endmodule

// File: tb/tb_tdc_spi_arbiter.sv
// Directed bench for tdc_spi_arbiter: SPI byte model, two requester drivers and a queue-based scoreboard.
module tb_tdc_spi_arbiter;
   localparam int TIMEOUT     = 1000;
   localparam int MAX_CONSEC  = 4;
   localparam logic [2:0] ST_WAIT_BYTE = 3'd2;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] state_o;

   always #5 clk = ~clk;

   tdc_spi_arbiter_if bus();

   tdc_spi_arbiter #(.MAX_CONSEC(MAX_CONSEC), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus),
      .state_o(state_o)
   );

   int total = 0;
   int bad = 0;
   int start_cnt = 0;
   int model_bytes = 1;
   int model_cnt = 0;
   bit model_silent = 1'b0;
   logic [7:0] miso_seq = 8'hC0;

   logic [7:0] tx_exp_q[$];
   logic [7:0] rx_exp_q[$];
   logic [1:0] done_exp_q[$];   // {port, err}

   logic [7:0] txbuf0[16];
   logic [7:0] txbuf1[16];
   int idx0 = 0;
   int idx1 = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [26:0] outs_vec();
      return {bus.grant0, bus.grant1, bus.tx_ack0, bus.tx_ack1, bus.rx_valid0, bus.rx_valid1,
              bus.rx_data, bus.done0, bus.done1, bus.err0, bus.err1, bus.m_start, bus.m_data_in};
   endfunction

   // SPI master model: each m_start yields one MISO byte; after model_bytes bytes it ends chip-select.
   initial begin
      bus.m_busy     = 1'b0;
      bus.m_new_data = 1'b0;
      bus.m_cs_end   = 1'b0;
      bus.m_data_out = 8'h00;
      forever begin
         @(negedge clk);
         if (!rst && bus.m_start && !model_silent) begin
            bus.m_busy = 1'b1;
            repeat (3) @(negedge clk);
            bus.m_data_out = miso_seq;
            rx_exp_q.push_back(miso_seq);
            miso_seq = miso_seq + 8'h07;
            bus.m_new_data = 1'b1;
            @(negedge clk);
            bus.m_new_data = 1'b0;
            bus.m_busy     = 1'b0;
            model_cnt++;
            if (model_cnt >= model_bytes) begin
               model_cnt = 0;
               @(negedge clk);
               bus.m_cs_end = 1'b1;
               @(negedge clk);
               bus.m_cs_end = 1'b0;
            end
         end
      end
   end

   // Requester drivers: present the next byte in the cycle tx_ack is seen.
   initial begin
      forever begin
         @(negedge clk);
         if (bus.tx_ack0 && idx0 < 15) begin
            idx0++;
            bus.tx0 = txbuf0[idx0];
         end
         if (bus.tx_ack1 && idx1 < 15) begin
            idx1++;
            bus.tx1 = txbuf1[idx1];
         end
      end
   end

   // Scoreboard: pops expected values as the DUT produces strobes.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (bus.grant0 | bus.grant1) check("grant_mutex", 32'(bus.grant0 & bus.grant1), 0);
            if (bus.m_start) begin
               start_cnt++;
               check("tx_exp_avail", 32'(tx_exp_q.size() > 0), 1);
               if (tx_exp_q.size() > 0) check("m_data_in", bus.m_data_in, tx_exp_q.pop_front());
            end
            if (bus.rx_valid0 | bus.rx_valid1) begin
               check("rx_exp_avail", 32'(rx_exp_q.size() > 0), 1);
               if (rx_exp_q.size() > 0) check("rx_data", bus.rx_data, rx_exp_q.pop_front());
               if (done_exp_q.size() > 0) begin
                  check("rx_port", {bus.rx_valid1, bus.rx_valid0}, done_exp_q[0][1] ? 2 : 1);
                  check("tx_ack_port", {bus.tx_ack1, bus.tx_ack0}, done_exp_q[0][1] ? 2 : 1);
               end
            end
            if (bus.done0 | bus.done1) begin
               check("done_exp_avail", 32'(done_exp_q.size() > 0), 1);
               if (done_exp_q.size() > 0)
                  check("done_port_err", {bus.done1, bus.err0 | bus.err1}, done_exp_q.pop_front());
            end
         end
      end
   end

   task automatic fill_buf(input int port, input logic [7:0] base, input logic [7:0] step);
      for (int i = 0; i < 16; i++) begin
         if (port == 0) txbuf0[i] = base + 8'(i) * step;
         else           txbuf1[i] = base + 8'(i) * step;
      end
      if (port == 0) begin idx0 = 0; bus.tx0 = txbuf0[0]; end
      else           begin idx1 = 0; bus.tx1 = txbuf1[0]; end
   endtask

   task automatic expect_txn(input int port, input int n_starts, input logic [7:0] base,
                             input logic [7:0] step, input logic err);
      for (int i = 0; i < n_starts; i++) tx_exp_q.push_back(base + 8'(i) * step);
      done_exp_q.push_back({port[0], err});
   endtask

   task automatic run_txn(input int port, input int len);
      int cnt;
      logic g;
      start_cnt   = 0;
      model_bytes = len;
      if (port == 0) begin bus.len0 = 4'(len); bus.req0 = 1'b1; end
      else           begin bus.len1 = 4'(len); bus.req1 = 1'b1; end
      cnt = 0;
      g = 1'b0;
      while (!g && cnt < 50) begin
         @(negedge clk);
         cnt++;
         g = (port == 0) ? bus.grant0 : bus.grant1;
      end
      check("grant_seen", 32'(g), 1);
      cnt = 0;
      while (((port == 0) ? bus.done0 : bus.done1) !== 1'b1 && cnt < 4 * TIMEOUT) begin
         check("grant_held", 32'((port == 0) ? bus.grant0 : bus.grant1), 1);
         @(negedge clk);
         cnt++;
      end
      check("done_seen", 32'((port == 0) ? bus.done0 : bus.done1), 1);
      if (port == 0) bus.req0 = 1'b0;
      else           bus.req1 = 1'b0;
      @(negedge clk);
      check("grant_drop", 32'((port == 0) ? bus.grant0 : bus.grant1), 0);
   endtask

   initial begin
      int cnt;
      int gcnt;
      int dcnt;
      int order[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

      rst = 1'b1;
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      bus.len0 = 4'd0; bus.len1 = 4'd0;
      bus.tx0  = 8'h00; bus.tx1  = 8'h00;
      repeat (3) @(negedge clk);
      check("reset_outputs", outs_vec(), 0);
      check("reset_state", state_o, 0);
      rst = 1'b0;
      @(negedge clk);

      // Port-1 write of three bytes
      fill_buf(1, 8'h01, 8'h01);
      expect_txn(1, 3, 8'h01, 8'h01, 1'b0);
      run_txn(1, 3);
      check("t1_starts", start_cnt, 3);

      // Both ports requesting continuously with single-byte transactions
      fill_buf(0, 8'h11, 8'h00);
      fill_buf(1, 8'h22, 8'h00);
      for (int k = 0; k < 10; k++) expect_txn(order[k], 1, order[k] ? 8'h22 : 8'h11, 8'h00, 1'b0);
      model_bytes = 1;
      start_cnt = 0;
      bus.len0 = 4'd1; bus.len1 = 4'd1;
      bus.req0 = 1'b1; bus.req1 = 1'b1;
      for (int k = 0; k < 10; k++) begin
         cnt = 0;
         do begin
            @(negedge clk);
            cnt++;
         end while (!(bus.done0 | bus.done1) && cnt < 200);
         check("order_done_seen", 32'(bus.done0 | bus.done1), 1);
      end
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      @(negedge clk);
      check("order_grants_off", {bus.grant1, bus.grant0}, 0);
      check("order_starts", start_cnt, 10);

      // Zero-length transaction
      fill_buf(0, 8'h55, 8'h00);
      expect_txn(0, 0, 8'h55, 8'h00, 1'b0);
      start_cnt = 0;
      bus.len0 = 4'd0;
      bus.req0 = 1'b1;
      gcnt = 0;
      dcnt = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus.grant0) gcnt++;
         if (bus.done0) begin dcnt++; bus.req0 = 1'b0; end
      end
      bus.req0 = 1'b0;
      check("len0_grant_cycles", gcnt, 1);
      check("len0_done_pulses", dcnt, 1);
      check("len0_starts", start_cnt, 0);

      // Silent SPI master: timeout abort, then a normal transaction
      fill_buf(0, 8'h61, 8'h01);
      expect_txn(0, 1, 8'h61, 8'h01, 1'b1);
      model_silent = 1'b1;
      bus.len0 = 4'd2;
      bus.req0 = 1'b1;
      cnt = 0;
      while (state_o !== ST_WAIT_BYTE && cnt < 50) begin @(negedge clk); cnt++; end
      check("tmo_wait_byte_seen", state_o, ST_WAIT_BYTE);
      cnt = 0;
      while (bus.done0 !== 1'b1 && cnt < 3 * TIMEOUT) begin @(negedge clk); cnt++; end
      check("tmo_cycles", cnt, TIMEOUT);
      check("tmo_err0", bus.err0, 1);
      bus.req0 = 1'b0;
      @(negedge clk);
      check("tmo_grant_drop", bus.grant0, 0);
      model_silent = 1'b0;
      fill_buf(1, 8'h71, 8'h01);
      expect_txn(1, 2, 8'h71, 8'h01, 1'b0);
      run_txn(1, 2);
      check("post_tmo_starts", start_cnt, 2);

      // Reset in the middle of a five-byte transaction
      fill_buf(1, 8'h81, 8'h01);
      tx_exp_q.push_back(8'h81);
      model_silent = 1'b1;
      bus.len1 = 4'd5;
      bus.req1 = 1'b1;
      cnt = 0;
      while (state_o !== ST_WAIT_BYTE && cnt < 50) begin @(negedge clk); cnt++; end
      check("rst_wait_byte_seen", state_o, ST_WAIT_BYTE);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_outputs", outs_vec(), 0);
      check("midrst_state", state_o, 0);
      model_silent = 1'b0;
      fill_buf(1, 8'h81, 8'h01);
      expect_txn(1, 5, 8'h81, 8'h01, 1'b0);
      rst = 1'b0;
      run_txn(1, 5);
      check("post_rst_starts", start_cnt, 5);

      // Port 0 drops req mid-transaction while port 1 becomes pending
      fill_buf(0, 8'h31, 8'h01);
      fill_buf(1, 8'h41, 8'h01);
      expect_txn(0, 4, 8'h31, 8'h01, 1'b0);
      expect_txn(1, 2, 8'h41, 8'h01, 1'b0);
      start_cnt = 0;
      model_bytes = 4;
      bus.len0 = 4'd4;
      bus.req0 = 1'b1;
      cnt = 0;
      while (bus.rx_valid0 !== 1'b1 && cnt < 200) begin @(negedge clk); cnt++; end
      check("drop_first_rx", bus.rx_valid0, 1);
      bus.req0 = 1'b0;
      bus.len1 = 4'd2;
      bus.req1 = 1'b1;
      cnt = 0;
      while (bus.done0 !== 1'b1 && cnt < 400) begin @(negedge clk); cnt++; end
      check("drop_done0", bus.done0, 1);
      check("drop_starts0", start_cnt, 4);
      model_bytes = 2;
      @(negedge clk);
      @(negedge clk);
      check("drop_grant1_next", bus.grant1, 1);
      cnt = 0;
      while (bus.done1 !== 1'b1 && cnt < 400) begin @(negedge clk); cnt++; end
      check("drop_done1", bus.done1, 1);
      bus.req1 = 1'b0;
      check("drop_starts_total", start_cnt, 6);

      repeat (5) @(negedge clk);
      check("tx_q_empty", tx_exp_q.size(), 0);
      check("rx_q_empty", rx_exp_q.size(), 0);
      check("done_q_empty", done_exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
